// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared encodings and constants for the sequential Vedic multiplier
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NSTEP = 4;
  localparam int NIB   = 4;

  // Shift applied to each partial product, indexed by step: {0,4,4,8}
  localparam logic [4*NSTEP-1:0] SHIFT_TAB = {4'd8, 4'd4, 4'd4, 4'd0};

  function automatic logic [3:0] shift_of(input logic [1:0] step);
    return SHIFT_TAB[{step, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/vedic_multiplier4x4bit.sv
// rtl/vedic_multiplier4x4bit.sv - combinational 4x4 Vedic (urdhva-tiryagbhyam) multiplier core
module vedic_multiplier4x4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // 2x2 vertical-and-crosswise cell built from half adders
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic       c1;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  logic [3:0] q0, q1, q2, q3;

  always_comb begin
    q0 = vm2(a[1:0], b[1:0]);
    q1 = vm2(a[3:2], b[1:0]);
    q2 = vm2(a[1:0], b[3:2]);
    q3 = vm2(a[3:2], b[3:2]);
    p  = {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
  end

endmodule

// File: rtl/vedic_mult8_seq_ctrl.sv
// rtl/vedic_mult8_seq_ctrl.sv - 8x8 multiplier time-sharing one 4x4 Vedic core over four steps
module vedic_mult8_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int OPW    = 8,
  parameter bit REG_PP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] product,
  output logic             busy
);

  localparam int         PW        = 2 * OPW;
  localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

  state_t          state, state_nx;
  logic [1:0]      step;
  logic [OPW-1:0]  a_q, b_q;
  logic [NIB-1:0]  nib_a, nib_b;
  logic [7:0]      pp;
  logic [PW-1:0]   pp_sh, pp_sh_q, addend, sum, acc;
  logic            add_en, last_add;

  // step[0] picks the high nibble of a, step[1] the high nibble of b
  always_comb begin
    nib_a = step[0] ? a_q[2*NIB-1:NIB] : a_q[NIB-1:0];
    nib_b = step[1] ? b_q[2*NIB-1:NIB] : b_q[NIB-1:0];
  end

  vedic_multiplier4x4bit u_core (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  always_comb begin
    pp_sh    = {{(PW-8){1'b0}}, pp} << shift_of(step);
    addend   = pp_sh;
    add_en   = 1'b0;
    last_add = 1'b0;
    if (REG_PP) begin
      // Registered path: each add lags its core step by one cycle, DRAIN takes the last
      addend   = pp_sh_q;
      add_en   = ((state == ST_MUL) && (step != 2'd0)) || (state == ST_DRAIN);
      last_add = (state == ST_DRAIN);
    end else begin
      add_en   = (state == ST_MUL);
      last_add = (state == ST_MUL) && (step == LAST_STEP);
    end
    sum = acc + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_MUL;
      ST_MUL:   if (step == LAST_STEP) state_nx = REG_PP ? ST_DRAIN : ST_DONE;
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      step    <= '0;
      acc     <= '0;
      pp_sh_q <= '0;
      product <= '0;
    end else begin
      pp_sh_q <= pp_sh;
      if ((state == ST_IDLE) && in_valid) begin
        a_q  <= a;
        b_q  <= b;
        step <= '0;
        acc  <= '0;
      end else begin
        if (state == ST_MUL) step <= step + 2'd1;
        if (add_en) acc <= sum;
        if (last_add) product <= sum;
      end
    end
  end

endmodule
